// File: rtl/goomba_sprite_gen.sv
// Goomba sprite generator: hit test, sprite ROM addressing, walk animation and life-cycle FSM.
// Optional left-facing mirroring is built when GOOMBA_MIRROR_EN is defined.
module goomba_sprite_gen #(
    parameter int SPRITE_W      = 16,
    parameter int SPRITE_H      = 16,
    parameter int WALK_PERIOD   = 8,
    parameter int SQUASH_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pix_valid,
    input  logic [9:0] goomba_x,
    input  logic [9:0] goomba_y,
    input  logic       facing_right,
    input  logic       stomp,
    input  logic       respawn,
    output logic [9:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic [3:0] palette_index,
    output logic       goomba_on,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        WALK     = 2'd0,
        SQUASHED = 2'd1,
        GONE     = 2'd2
    } gstate_t;

    localparam logic [7:0]  WALK_LAST   = 8'(WALK_PERIOD - 1);
    localparam logic [7:0]  SQUASH_INIT = 8'(SQUASH_FRAMES);
    localparam logic [10:0] EXT_W       = 11'(SPRITE_W);
    localparam logic [10:0] EXT_H       = 11'(SPRITE_H);

    gstate_t    state_r;
    gstate_t    state_nxt;
    logic [9:0] gx_sh;
    logic [9:0] gy_sh;
    logic       face_sh;
    logic [7:0] anim_cnt;
    logic [7:0] squash_cnt;
    logic       walk_frame;

    // Left-facing art is the right-facing art read back to front (15-col).
    function automatic logic [3:0] mirror_col(input logic [3:0] col, input logic face_right);
        return face_right ? col : ~col;
    endfunction

    // Position is latched only at vertical blank so a frame never tears.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            gx_sh <= '0;
            gy_sh <= '0;
        end else if (frame_start) begin
            gx_sh <= goomba_x;
            gy_sh <= goomba_y;
        end
    end

`ifdef GOOMBA_MIRROR_EN
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            face_sh <= 1'b1;
        end else if (frame_start) begin
            face_sh <= facing_right;
        end
    end
`else
    logic unused_facing;
    assign unused_facing = facing_right;
    assign face_sh       = 1'b1;
`endif

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= WALK;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        if (respawn) begin
            state_nxt = WALK;
        end else begin
            case (state_r)
                WALK:     if (stomp) state_nxt = SQUASHED;
                SQUASHED: if (frame_start && squash_cnt == 8'd1) state_nxt = GONE;
                GONE:     state_nxt = GONE;
                default:  state_nxt = WALK;
            endcase
        end
    end

    // A stomp in WALK takes priority over the frame tick, so the animation freezes on that frame.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_cnt   <= '0;
            walk_frame <= 1'b0;
            squash_cnt <= '0;
        end else if (respawn) begin
            anim_cnt   <= '0;
            walk_frame <= 1'b0;
            squash_cnt <= '0;
        end else if (state_r == WALK && stomp) begin
            squash_cnt <= SQUASH_INIT;
        end else if (frame_start) begin
            if (state_r == WALK) begin
                if (anim_cnt == WALK_LAST) begin
                    anim_cnt   <= '0;
                    walk_frame <= ~walk_frame;
                end else begin
                    anim_cnt <= anim_cnt + 8'd1;
                end
            end else if (state_r == SQUASHED) begin
                squash_cnt <= squash_cnt - 8'd1;
            end
        end
    end

    logic [10:0] x_ext, y_ext, gx_ext, gy_ext;
    logic        hit;
    logic [3:0]  row, col;
    logic [1:0]  frame_sel;

    // Widened compare: a sprite past the right/bottom edge clips instead of wrapping.
    always_comb begin
        x_ext     = {1'b0, DrawX};
        y_ext     = {1'b0, DrawY};
        gx_ext    = {1'b0, gx_sh};
        gy_ext    = {1'b0, gy_sh};
        hit       = pix_valid
                  && (x_ext >= gx_ext) && (x_ext < gx_ext + EXT_W)
                  && (y_ext >= gy_ext) && (y_ext < gy_ext + EXT_H);
        row       = DrawY[3:0] - gy_sh[3:0];
        col       = mirror_col(DrawX[3:0] - gx_sh[3:0], face_sh);
        frame_sel = (state_r == WALK) ? {1'b0, walk_frame} : 2'b10;
    end

    logic    hit_p1;
    gstate_t state_p1;
    logic    opaque;

    // Stage 1: ROM address and qualifiers for the pixel
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            hit_p1   <= 1'b0;
            state_p1 <= WALK;
        end else begin
            rom_addr <= {frame_sel, row, col};
            hit_p1   <= hit;
            state_p1 <= state_r;
        end
    end

    assign opaque = hit_p1 && (state_p1 != GONE) && (rom_data != 4'd0);

    // Stage 2: palette index and visibility, aligned to the ROM read
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            goomba_on     <= 1'b0;
            palette_index <= '0;
        end else begin
            goomba_on     <= opaque;
            palette_index <= opaque ? rom_data : 4'd0;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_goomba_sprite_gen.sv
// Scoreboard bench for goomba_sprite_gen with a frame-counting reference model and a combinational ROM.
module tb_goomba_sprite_gen;

    localparam int WP = 8;
    localparam int SF = 30;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       pix_valid = 1'b0;
    logic [9:0] goomba_x = '0;
    logic [9:0] goomba_y = '0;
    logic       facing_right = 1'b1;
    logic       stomp = 1'b0;
    logic       respawn = 1'b0;
    logic [9:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] palette_index;
    logic       goomba_on;
    logic [1:0] state;

    logic [3:0] rom [0:1023];
    assign rom_data = rom[rom_addr];

    goomba_sprite_gen #(
        .SPRITE_W(16), .SPRITE_H(16), .WALK_PERIOD(WP), .SQUASH_FRAMES(SF)
    ) dut (
        .Clk(Clk), .reset_n(reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
        .goomba_x(goomba_x), .goomba_y(goomba_y), .facing_right(facing_right),
        .stomp(stomp), .respawn(respawn), .rom_addr(rom_addr), .rom_data(rom_data),
        .palette_index(palette_index), .goomba_on(goomba_on), .state(state)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] addr;
        bit         chk_addr;
        bit         on;
        logic [3:0] idx;
    } exp_t;

    exp_t addr_q[$];
    exp_t out_q[$];
    logic issue = 1'b0;
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= issue;
            v2 <= v1;
        end
    end

    // Reference model: game state expressed as frame counts since the last event.
    int m_gx = 0, m_gy = 0, m_state = 0, m_walk_frames = 0, m_squash_frames = 0;
    bit m_face = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (v1) begin
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL addr_queue_empty at %0t", $time);
            end else begin
                e = addr_q.pop_front();
                if (e.chk_addr) begin
                    checks++;
                    if (rom_addr !== e.addr) begin
                        errors++;
                        $display("FAIL rom_addr: got %03h expected %03h at %0t", rom_addr, e.addr, $time);
                    end
                end
            end
        end
        if (v2) begin
            if (out_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_queue_empty at %0t", $time);
            end else begin
                e = out_q.pop_front();
                checks++;
                if (goomba_on !== e.on || palette_index !== e.idx) begin
                    errors++;
                    $display("FAIL pixel_out: got on=%0b idx=%0d expected on=%0b idx=%0d at %0t",
                             goomba_on, palette_index, e.on, e.idx, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y, input bit pv);
        exp_t e;
        int   row, col, frame;
        bit   hit;
        hit   = pv && x >= m_gx && x < m_gx + 16 && y >= m_gy && y < m_gy + 16;
        row   = y - m_gy;
        col   = x - m_gx;
`ifdef GOOMBA_MIRROR_EN
        if (!m_face) col = 15 - col;
`endif
        frame = (m_state == 0) ? ((m_walk_frames / WP) % 2) : 2;
        e.chk_addr = hit && (m_state != 2);
        e.addr     = 10'(frame * 256 + row * 16 + col);
        e.on       = e.chk_addr && (rom[e.addr] != 4'd0);
        e.idx      = e.on ? rom[e.addr] : 4'd0;
        addr_q.push_back(e);
        out_q.push_back(e);
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        pix_valid = pv;
        issue     = 1'b1;
        step();
        issue     = 1'b0;
    endtask

    task automatic pulse(input bit fs, input bit st, input bit rs);
        frame_start = fs;
        stomp       = st;
        respawn     = rs;
        step();
        frame_start = 1'b0;
        stomp       = 1'b0;
        respawn     = 1'b0;
        if (fs) begin
            m_gx   = int'(goomba_x);
            m_gy   = int'(goomba_y);
            m_face = facing_right;
        end
        if (rs) begin
            m_state = 0; m_walk_frames = 0; m_squash_frames = 0;
        end else if (st && m_state == 0) begin
            m_state = 1; m_squash_frames = 0;
        end else if (fs) begin
            if (m_state == 0) begin
                m_walk_frames++;
            end else if (m_state == 1) begin
                m_squash_frames++;
                if (m_squash_frames == SF) m_state = 2;
            end
        end
        chk("state", int'(state), m_state);
    endtask

    task automatic near_pixel();
        int x, y;
        x = m_gx + int'($urandom_range(0, 23)) - 4;
        y = m_gy + int'($urandom_range(0, 23)) - 4;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        pixel(x, y, $urandom_range(0, 7) != 0);
    endtask

    task automatic drain();
        repeat (3) step();
        chk("queues_drained", addr_q.size() + out_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rom[0] = 4'd5;
        rom[10'h02C] = 4'd0;
        rom[10'h023] = 4'd0;
        rom[9] = 4'd7; rom[265] = 4'd7; rom[6] = 4'd7; rom[262] = 4'd7;

        #12;
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_palette", int'(palette_index), 0);
        chk("reset_goomba_on", int'(goomba_on), 0);
        chk("reset_state", int'(state), 0);
        @(negedge Clk);
        reset_n = 1'b1;
        step();

        // Basic hit at the sprite origin and its edges
        goomba_x = 10'd100; goomba_y = 10'd200; facing_right = 1'b1;
        pulse(1, 0, 0);
        pixel(100, 200, 1);
        pixel(116, 200, 1);
        pixel(115, 215, 1);
        pixel(99, 200, 1);
        pixel(100, 216, 1);
        pixel(100, 200, 0);

        // Facing left, then transparency on the mirrored texel
        facing_right = 1'b0;
        pulse(1, 0, 0);
        pixel(103, 202, 1);
        pixel(112, 202, 1);
        facing_right = 1'b1;

        // Mid-frame move must not take effect before frame_start
        goomba_x = 10'd300;
        pixel(101, 201, 1);
        pixel(300, 201, 1);
        goomba_x = 10'd100;

        // Walk animation over two full periods after a clean respawn
        pulse(0, 0, 1);
        for (int f = 0; f < 2 * WP; f++) begin
            pulse(1, 0, 0);
            pixel(100, 200, 1);
            near_pixel();
        end

        // Squash life-cycle
        pulse(0, 1, 0);
        pixel(105, 205, 1);
        for (int f = 0; f < SF; f++) begin
            pulse(1, 0, 0);
            pixel(100 + f % 16, 200 + f % 16, 1);
        end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) pixel(100 + c, 200 + r, 1);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        pulse(0, 1, 1);
        for (int f = 0; f < WP; f++) begin
            pixel(100, 200, 1);
            pulse(1, 0, 0);
        end
        pixel(100, 200, 1);
        pulse(1, 1, 0);
        pixel(100, 200, 1);
        pulse(0, 0, 1);

        // Clipping at the right screen edge
        goomba_x = 10'd630; goomba_y = 10'd100;
        pulse(1, 0, 0);
        pixel(639, 100, 1);
        pixel(0, 100, 1);
        pixel(645, 100, 1);

        // Randomized events and pixels
        for (int it = 0; it < 800; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                goomba_x = 10'($urandom_range(0, 700));
                goomba_y = 10'($urandom_range(0, 500));
                facing_right = 1'($urandom_range(0, 1));
            end else if (r < 15) pulse(1, 0, 0);
            else if (r < 17) pulse(0, 1, 0);
            else if (r < 18) pulse(0, 0, 1);
            else if (r < 19) pulse(0, 1, 1);
            else if (r < 20) pulse(1, 1, 0);
            else begin
                repeat (4) near_pixel();
            end
        end
        drain();

        // Asynchronous reset while a visible pixel is in the pipeline
        pulse(0, 0, 1);
        goomba_x = 10'd200; goomba_y = 10'd50; facing_right = 1'b1;
        pulse(1, 0, 0);
        rom[0] = 4'd5; rom[256] = 4'd5;
        DrawX = 10'd200; DrawY = 10'd50; pix_valid = 1'b1;
        repeat (3) step();
        chk("pre_reset_on", int'(goomba_on), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_on", int'(goomba_on), 0);
        chk("async_reset_palette", int'(palette_index), 0);
        chk("async_reset_addr", int'(rom_addr), 0);
        chk("async_reset_state", int'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
